// File: rtl/alu_exec_sequencer_pkg.sv
// Shared definitions for the group-01 execute stage.
// Contents:
//  - aaa operation codes for cc=01 opcodes, plus the cc group code
//  - the bbb addressing code that selects an immediate operand
//  - bit indices of the processor status register P and its reset value
//  - FSM state encoding
//  - a small opcode field helper
package alu_exec_sequencer_pkg;

    // aaa field of a cc=01 opcode (aaabbbcc)
    localparam logic [2:0] OP01_ORA = 3'b000;
    localparam logic [2:0] OP01_AND = 3'b001;
    localparam logic [2:0] OP01_EOR = 3'b010;
    localparam logic [2:0] OP01_ADC = 3'b011;
    localparam logic [2:0] OP01_STA = 3'b100;
    localparam logic [2:0] OP01_LDA = 3'b101;
    localparam logic [2:0] OP01_CMP = 3'b110;
    localparam logic [2:0] OP01_SBC = 3'b111;

    localparam logic [1:0] CC_GRP01 = 2'b01;

    // bbb=010 in group 01 means "immediate operand"
    localparam logic [2:0] AM3_IMM  = 3'b010;

    // P = N V 1 B D I Z C
    localparam int P_N = 7;
    localparam int P_V = 6;
    localparam int P_U = 5;
    localparam int P_B = 4;
    localparam int P_D = 3;
    localparam int P_I = 2;
    localparam int P_Z = 1;
    localparam int P_C = 0;
    localparam logic [7:0] P_RESET = 8'h24;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_EXEC  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // An opcode is rejected when it is outside group 01, or when it asks
    // for an immediate store (STA #imm has no meaning).
    function automatic logic op_is_illegal(input logic [7:0] op);
        return (op[1:0] != CC_GRP01) ||
               ((op[7:5] == OP01_STA) && (op[4:2] == AM3_IMM));
    endfunction

endpackage

// File: rtl/alu_exec_sequencer_alu8.sv
// Combinational group-01 ALU.
// Ports:
//  op       in  3  aaa operation code
//  a        in  W  accumulator
//  m        in  W  operand
//  c_in     in  1  current carry flag
//  v_in     in  1  current overflow flag
//  result   out W  operation result (compare difference for CMP)
//  n, z     out 1  negative / zero of result
//  c, v     out 1  new carry / overflow (pass-through when the op leaves them)
//  write_a  out 1  result should be written into A
module alu_exec_sequencer_alu8
    import alu_exec_sequencer_pkg::*;
#(
    parameter int REG_WIDTH = 8
) (
    input  logic [2:0]           op,
    input  logic [REG_WIDTH-1:0] a,
    input  logic [REG_WIDTH-1:0] m,
    input  logic                 c_in,
    input  logic                 v_in,
    output logic [REG_WIDTH-1:0] result,
    output logic                 n,
    output logic                 z,
    output logic                 c,
    output logic                 v,
    output logic                 write_a
);

    logic [REG_WIDTH:0]   sum;
    logic [REG_WIDTH-1:0] m_eff;

    always_comb begin
        result  = a;
        c       = c_in;
        v       = v_in;
        write_a = 1'b0;
        sum     = '0;
        m_eff   = m;
        case (op)
            OP01_ORA: begin result = a | m; write_a = 1'b1; end
            OP01_AND: begin result = a & m; write_a = 1'b1; end
            OP01_EOR: begin result = a ^ m; write_a = 1'b1; end
            OP01_LDA: begin result = m;     write_a = 1'b1; end
            OP01_ADC, OP01_SBC: begin
                // SBC is ADC of the complemented operand; the carry acts
                // as "not borrow", so no extra +1 is needed.
                m_eff   = (op == OP01_SBC) ? ~m : m;
                sum     = {1'b0, a} + {1'b0, m_eff} + {{REG_WIDTH{1'b0}}, c_in};
                result  = sum[REG_WIDTH-1:0];
                c       = sum[REG_WIDTH];
                v       = (a[REG_WIDTH-1] == m_eff[REG_WIDTH-1]) &&
                          (sum[REG_WIDTH-1] != a[REG_WIDTH-1]);
                write_a = 1'b1;
            end
            OP01_CMP: begin
                sum    = {1'b0, a} - {1'b0, m};
                result = sum[REG_WIDTH-1:0];
                c      = (a >= m);
            end
            default: begin
                // STA: nothing computed, A and flags untouched
                result = a;
            end
        endcase
        n = result[REG_WIDTH-1];
        z = (result == '0);
    end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Execute stage for group-01 (cc=01) opcodes, downstream of the fetcher.
// Accepts one opcode with its effective address / immediate byte, performs
// the memory read or write it needs, runs the ALU and updates A and P, then
// pulses get_next so the fetcher can start on the next instruction.
// Ports:
//  clk, reset_n     clock, synchronous active-low reset
//  instr_valid      opcode/eff_addr/imm_data are ready (sampled only in IDLE)
//  opcode           aaabbbcc
//  eff_addr         operand address (ignored for immediate)
//  imm_data         immediate operand
//  mem_rdata        read data, valid the cycle after mem_re
//  get_next         1-cycle retire pulse
//  busy             high in every state except IDLE
//  illegal          1-cycle pulse alongside get_next for rejected opcodes
//  mem_addr/re/we/wdata  memory bus
//  a_out, status_out     accumulator and P
module alu_exec_sequencer
    import alu_exec_sequencer_pkg::*;
#(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  instr_valid,
    input  logic [7:0]            opcode,
    input  logic [ADDR_WIDTH-1:0] eff_addr,
    input  logic [REG_WIDTH-1:0]  imm_data,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    output logic                  get_next,
    output logic                  busy,
    output logic                  illegal,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic                  mem_we,
    output logic [REG_WIDTH-1:0]  mem_wdata,
    output logic [REG_WIDTH-1:0]  a_out,
    output logic [7:0]            status_out
);

    state_t                state_reg,   state_next;
    logic [2:0]            aaa_reg,     aaa_next;
    logic [ADDR_WIDTH-1:0] addr_reg,    addr_next;
    logic [REG_WIDTH-1:0]  operand_reg, operand_next;
    logic                  illegal_reg, illegal_next;
    logic [REG_WIDTH-1:0]  a_reg,       a_next;
    logic [7:0]            p_reg,       p_next;

    logic [REG_WIDTH-1:0]  alu_result;
    logic                  alu_n, alu_z, alu_c, alu_v, alu_write_a;

    alu_exec_sequencer_alu8 #(
        .REG_WIDTH (REG_WIDTH)
    ) u_alu (
        .op      (aaa_reg),
        .a       (a_reg),
        .m       (operand_reg),
        .c_in    (p_reg[P_C]),
        .v_in    (p_reg[P_V]),
        .result  (alu_result),
        .n       (alu_n),
        .z       (alu_z),
        .c       (alu_c),
        .v       (alu_v),
        .write_a (alu_write_a)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg   <= ST_IDLE;
            aaa_reg     <= '0;
            addr_reg    <= '0;
            operand_reg <= '0;
            illegal_reg <= 1'b0;
            a_reg       <= '0;
            p_reg       <= P_RESET;
        end else begin
            state_reg   <= state_next;
            aaa_reg     <= aaa_next;
            addr_reg    <= addr_next;
            operand_reg <= operand_next;
            illegal_reg <= illegal_next;
            a_reg       <= a_next;
            p_reg       <= p_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        aaa_next     = aaa_reg;
        addr_next    = addr_reg;
        operand_next = operand_reg;
        illegal_next = illegal_reg;
        a_next       = a_reg;
        p_next       = p_reg;

        case (state_reg)
            ST_IDLE: begin
                if (instr_valid) begin
                    aaa_next     = opcode[7:5];
                    addr_next    = eff_addr;
                    operand_next = imm_data;
                    illegal_next = op_is_illegal(opcode);
                    if (op_is_illegal(opcode))
                        state_next = ST_DONE;
                    else if (opcode[4:2] == AM3_IMM)
                        state_next = ST_EXEC;
                    else if (opcode[7:5] == OP01_STA)
                        state_next = ST_WRITE;
                    else
                        state_next = ST_READ;
                end
            end
            ST_READ:  state_next = ST_WAIT;
            ST_WAIT: begin
                operand_next = mem_rdata;
                state_next   = ST_EXEC;
            end
            ST_WRITE: state_next = ST_DONE;
            ST_EXEC: begin
                if (alu_write_a)
                    a_next = alu_result;
                p_next[P_N] = alu_n;
                p_next[P_Z] = alu_z;
                p_next[P_C] = alu_c;
                p_next[P_V] = alu_v;
                state_next  = ST_DONE;
            end
            ST_DONE: begin
                illegal_next = 1'b0;
                state_next   = ST_IDLE;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    // Bus outputs are decoded from state so both strobes are provably
    // exclusive and the bus reads idle (all zero) outside READ/WRITE.
    assign mem_re     = (state_reg == ST_READ);
    assign mem_we     = (state_reg == ST_WRITE);
    assign mem_addr   = (mem_re || mem_we) ? addr_reg : '0;
    assign mem_wdata  = mem_we ? a_reg : '0;
    assign get_next   = (state_reg == ST_DONE);
    assign illegal    = (state_reg == ST_DONE) && illegal_reg;
    assign busy       = (state_reg != ST_IDLE);
    assign a_out      = a_reg;
    assign status_out = p_reg;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
module tb_alu_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic [7:0]  opcode = 8'h00;
    logic [15:0] eff_addr = 16'h0000;
    logic [7:0]  imm_data = 8'h00;
    logic [7:0]  mem_rdata = 8'h00;
    logic        get_next, busy, illegal, mem_re, mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata, a_out, status_out;

    int n_cmp = 0;
    int n_err = 0;

    // per-transaction observations
    int          gn_cyc, gn_cnt, re_cnt, we_cnt, ill_cyc, both_cnt;
    logic [15:0] re_addr, we_addr;
    logic [7:0]  wdata_seen;

    alu_exec_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .eff_addr    (eff_addr),
        .imm_data    (imm_data),
        .mem_rdata   (mem_rdata),
        .get_next    (get_next),
        .busy        (busy),
        .illegal     (illegal),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .a_out       (a_out),
        .status_out  (status_out)
    );

    always #5 clk = ~clk;

    // Memory: data appears the cycle after mem_re.
    always @(posedge clk) begin
        if (mem_re)
            mem_rdata <= (mem_addr == 16'h0010) ? 8'h01 : 8'hEE;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Present one instruction for one clock, then watch 6 cycles.
    task automatic issue(input string name, input logic [7:0] op,
                         input logic [15:0] addr, input logic [7:0] imm);
        @(negedge clk);
        opcode = op; eff_addr = addr; imm_data = imm; instr_valid = 1'b1;
        gn_cyc = 0; gn_cnt = 0; re_cnt = 0; we_cnt = 0; ill_cyc = 0; both_cnt = 0;
        re_addr = '0; we_addr = '0; wdata_seen = '0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            instr_valid = 1'b0;
            if (get_next) begin
                gn_cnt++;
                if (gn_cyc == 0) gn_cyc = cyc;
            end
            if (mem_re) begin re_cnt++; re_addr = mem_addr; end
            if (mem_we) begin we_cnt++; we_addr = mem_addr; wdata_seen = mem_wdata; end
            if (illegal) ill_cyc = cyc;
            if (mem_re && mem_we) both_cnt++;
        end
        $display("txn %-10s op=%02h addr=%04h imm=%02h -> get_next@%0d re=%0d we=%0d illegal@%0d A=%02h P=%02h",
                 name, op, addr, imm, gn_cyc, re_cnt, we_cnt, ill_cyc, a_out, status_out);
    endtask

    initial begin
        // ---- reset ----
        repeat (2) @(negedge clk);
        check("rst_a", a_out, 8'h00);
        check("rst_p", status_out, 8'h24);
        check("rst_busy", busy, 1'b0);
        check("rst_get_next", get_next, 1'b0);
        check("rst_strobes", {mem_re, mem_we, illegal}, 3'b000);
        check("rst_bus", {mem_addr, mem_wdata}, 24'h0);
        reset_n = 1'b1;

        // ---- LDA #$80 ----
        issue("LDA#80", 8'hA9, 16'hFFFF, 8'h80);
        check("lda_lat", gn_cyc, 2);
        check("lda_gn_cnt", gn_cnt, 1);
        check("lda_a", a_out, 8'h80);
        check("lda_p", status_out, 8'hA4);
        check("lda_no_strobe", re_cnt + we_cnt, 0);

        // ---- ADC #$50 with A=$50, C=0 ----
        issue("LDA#50", 8'hA9, 16'h0000, 8'h50);
        check("lda50_p", status_out, 8'h24);
        issue("ADC#50", 8'h69, 16'h0000, 8'h50);
        check("adc_imm_a", a_out, 8'hA0);
        check("adc_imm_p", status_out, 8'hE4);

        // ---- ADC $10 with A=$FF, C=0, mem[$10]=$01 ----
        issue("LDA#FF", 8'hA9, 16'h0000, 8'hFF);
        check("ldaff_p", status_out, 8'hE4);
        issue("ADC$10", 8'h65, 16'h0010, 8'h00);
        check("adc_mem_lat", gn_cyc, 4);
        check("adc_mem_re_cnt", re_cnt, 1);
        check("adc_mem_re_addr", re_addr, 16'h0010);
        check("adc_mem_we_cnt", we_cnt, 0);
        check("adc_mem_a", a_out, 8'h00);
        check("adc_mem_p", status_out, 8'h27);

        // ---- STA $1234 with A=$42 ----
        issue("LDA#42", 8'hA9, 16'h0000, 8'h42);
        check("lda42_p", status_out, 8'h25);
        issue("STA$1234", 8'h8D, 16'h1234, 8'h00);
        check("sta_lat", gn_cyc, 2);
        check("sta_we_cnt", we_cnt, 1);
        check("sta_re_cnt", re_cnt, 0);
        check("sta_addr", we_addr, 16'h1234);
        check("sta_wdata", wdata_seen, 8'h42);
        check("sta_a", a_out, 8'h42);
        check("sta_p", status_out, 8'h25);

        // ---- CMP #$20 with A=$10 ----
        issue("LDA#10", 8'hA9, 16'h0000, 8'h10);
        issue("CMP#20", 8'hC9, 16'h0000, 8'h20);
        check("cmp_a", a_out, 8'h10);
        check("cmp_p", status_out, 8'hA4);

        // ---- illegal $EA ----
        issue("ILL$EA", 8'hEA, 16'h5555, 8'h99);
        check("ill_lat", gn_cyc, 1);
        check("ill_pulse", ill_cyc, 1);
        check("ill_strobes", re_cnt + we_cnt, 0);
        check("ill_a", a_out, 8'h10);
        check("ill_p", status_out, 8'hA4);

        // ---- illegal STA #imm ($89) ----
        issue("STA#imm", 8'h89, 16'h0000, 8'h00);
        check("sta_imm_ill", ill_cyc, 1);
        check("sta_imm_we", we_cnt, 0);

        check("no_both_strobes", both_cnt, 0);

        // ---- reset during WAIT ----
        @(negedge clk);
        opcode = 8'h65; eff_addr = 16'h0010; imm_data = 8'h00; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        check("abort_read", mem_re, 1'b1);
        @(negedge clk);                  // now in WAIT
        check("abort_in_wait", {busy, mem_re}, 2'b10);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_idle", busy, 1'b0);
        check("abort_a", a_out, 8'h00);
        check("abort_p", status_out, 8'h24);
        reset_n = 1'b1;
        gn_cnt = 0; re_cnt = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (get_next) gn_cnt++;
            if (mem_re || mem_we) re_cnt++;
            @(negedge clk);
        end
        check("abort_no_get_next", gn_cnt, 0);
        check("abort_no_strobe", re_cnt, 0);
        $display("txn %-10s reset in WAIT -> A=%02h P=%02h", "ABORT", a_out, status_out);

        // ---- instr_valid held high while busy is not re-accepted ----
        opcode = 8'hA9; imm_data = 8'h01; instr_valid = 1'b1;
        gn_cnt = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                // change the operand while busy; it must not be picked up
                imm_data = 8'h77;
                opcode   = 8'h09;
            end
            if (get_next) begin
                gn_cnt++;
                instr_valid = 1'b0;
            end
        end
        check("hold_gn_cnt", gn_cnt, 1);
        check("hold_a", a_out, 8'h01);
        check("hold_p", status_out, 8'h24);
        $display("txn %-10s LDA#01 held valid -> get_next x%0d A=%02h P=%02h",
                 "HOLD", gn_cnt, a_out, status_out);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
